// File: rtl/lcd_link_pkg.sv
// Shared definitions for the serial LCD text link: escape byte, default
// substitution character and the sender's state encoding.
package lcd_link_pkg;

  localparam logic [7:0] ESC_BYTE         = 8'h00;
  localparam logic [7:0] DEFAULT_SUB_CHAR = 8'h20;

  typedef enum logic [1:0] {
    IDLE,
    ESC,
    BYTE,
    GAP
  } lcd_state_t;

endpackage

// File: rtl/lcd_serial_sender_if.sv
// Request channel into the LCD serial sender: a character or instruction byte
// offered under a valid/ready handshake.
interface lcd_serial_sender_if;

  logic       in_valid;
  logic       in_ready;
  logic       in_is_cmd;
  logic [7:0] in_data;

  modport master (output in_valid, output in_is_cmd, output in_data, input in_ready);
  modport slave  (input in_valid, input in_is_cmd, input in_data, output in_ready);

endinterface

// File: rtl/lcd_serial_sender_uart_tx_frame.sv
// One 8N1 UART frame, LSB first. A start request on the final stop-bit clock
// chains the next frame with no idle bit in between.
module uart_tx_frame #(
  parameter int unsigned CLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [7:0] data,
  output logic       TxD,
  output logic       done
);

  localparam int unsigned      CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] clk_cnt;
  logic [3:0]       bit_idx;
  logic [7:0]       shreg;
  logic             active;

  // bit_idx 0 = start, 1..8 = data bits, 9 = stop
  assign done = active && (bit_idx == 4'd9) && (clk_cnt == LAST_CNT);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      TxD     <= 1'b1;
      clk_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      active  <= 1'b0;
    end else if (start) begin
      TxD     <= 1'b0;
      clk_cnt <= '0;
      bit_idx <= '0;
      shreg   <= data;
      active  <= 1'b1;
    end else if (active) begin
      if (clk_cnt == LAST_CNT) begin
        clk_cnt <= '0;
        if (bit_idx == 4'd9) begin
          active <= 1'b0;
          TxD    <= 1'b1;
        end else begin
          bit_idx <= bit_idx + 4'd1;
          TxD     <= (bit_idx == 4'd8) ? 1'b1 : shreg[bit_idx[2:0]];
        end
      end else begin
        clk_cnt <= clk_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/lcd_serial_sender.sv
// Host-side sender for the serial LCD link: accepts character/instruction
// requests, frames them as UART bytes and enforces a settle gap afterwards.
module lcd_serial_sender
  import lcd_link_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT  = 217,
  parameter int unsigned DATA_GAP_CLKS = 1250,
  parameter int unsigned CMD_GAP_CLKS  = 50000,
  parameter logic [7:0]  SUB_CHAR      = DEFAULT_SUB_CHAR
) (
  input  logic                clk,
  input  logic                resetn,
  lcd_serial_sender_if.slave  in_if,
  output logic                TxD,
  output logic                busy,
  output logic                sub_flag
);

  localparam int unsigned GAP_MAX = (CMD_GAP_CLKS > DATA_GAP_CLKS) ? CMD_GAP_CLKS : DATA_GAP_CLKS;
  localparam int unsigned GAP_W   = $clog2(GAP_MAX + 1);

  lcd_state_t       state, state_nx;
  logic             cmd_q;
  logic [7:0]       byte_q;
  logic [GAP_W-1:0] gap_cnt;
  logic [GAP_W-1:0] gap_load;
  logic             accept;
  logic             frame_start;
  logic             frame_done;
  logic [7:0]       frame_data;
  logic [7:0]       req_byte;
  logic             req_sub;

  assign in_if.in_ready = (state == IDLE) && resetn;
  assign accept         = in_if.in_valid && in_if.in_ready;
  assign busy           = (state != IDLE);
  // 0x00 is the link escape, so it can never travel as a character
  assign req_sub        = !in_if.in_is_cmd && (in_if.in_data == ESC_BYTE);
  assign req_byte       = req_sub ? SUB_CHAR : in_if.in_data;
  assign gap_load       = cmd_q ? GAP_W'(CMD_GAP_CLKS) : GAP_W'(DATA_GAP_CLKS);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  // Frame start is issued on the accept edge itself so the start bit is
  // registered onto TxD the very next cycle.
  always_comb begin
    state_nx    = state;
    frame_start = 1'b0;
    frame_data  = byte_q;
    case (state)
      IDLE: begin
        if (accept) begin
          frame_start = 1'b1;
          if (in_if.in_is_cmd) begin
            state_nx   = ESC;
            frame_data = ESC_BYTE;
          end else begin
            state_nx   = BYTE;
            frame_data = req_byte;
          end
        end
      end
      ESC: begin
        if (frame_done) begin
          frame_start = 1'b1;
          state_nx    = BYTE;
        end
      end
      BYTE: begin
        if (frame_done) state_nx = (gap_load == '0) ? IDLE : GAP;
      end
      GAP: begin
        if (gap_cnt <= GAP_W'(1)) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cmd_q    <= 1'b0;
      byte_q   <= '0;
      gap_cnt  <= '0;
      sub_flag <= 1'b0;
    end else begin
      sub_flag <= accept && req_sub;
      if (accept) begin
        cmd_q  <= in_if.in_is_cmd;
        byte_q <= req_byte;
      end
      if (state == BYTE && frame_done) gap_cnt <= gap_load;
      else if (state == GAP)           gap_cnt <= gap_cnt - GAP_W'(1);
    end
  end

  uart_tx_frame #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_frame (
    .clk    (clk),
    .resetn (resetn),
    .start  (frame_start),
    .data   (frame_data),
    .TxD    (TxD),
    .done   (frame_done)
  );

endmodule

// File: tb/tb_lcd_serial_sender.sv
// Directed and randomized checks of lcd_serial_sender against a cycle-level
// waveform model of the LCD link protocol plus a UART byte decoder.
module tb_lcd_serial_sender;

  localparam int unsigned CPB      = 4;
  localparam int unsigned DATA_GAP = 8;
  localparam int unsigned CMD_GAP  = 20;

  logic clk;
  logic resetn;
  logic txd;
  logic busy;
  logic sub_flag;

  int unsigned errors;
  int unsigned checks;

  lcd_serial_sender_if ifc ();

  lcd_serial_sender #(
    .CLKS_PER_BIT  (CPB),
    .DATA_GAP_CLKS (DATA_GAP),
    .CMD_GAP_CLKS  (CMD_GAP)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .in_if    (ifc.slave),
    .TxD      (txd),
    .busy     (busy),
    .sub_flag (sub_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input int idx, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
    end
  endtask

  // One request: waits for in_ready (bounded), offers it, then checks every
  // following cycle against the waveform the link protocol prescribes.
  task automatic run_req(input logic is_cmd, input logic [7:0] d, input logic hold,
                         input logic nxt_cmd, input logic [7:0] nxt_d);
    logic        exp_q[$];
    logic        cap[$];
    logic [7:0]  bytes_q[$];
    logic [7:0]  dec_q[$];
    logic [7:0]  cur;
    logic [7:0]  acc;
    logic        exp_sub;
    int unsigned gap;
    int unsigned waited;
    int unsigned k;

    waited = 0;
    while (ifc.in_ready !== 1'b1 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    check_val("ready_before_req", int'(d), int'(ifc.in_ready), 1);

    if (is_cmd) begin
      bytes_q.push_back(8'h00);
      bytes_q.push_back(d);
      gap = CMD_GAP;
    end else begin
      bytes_q.push_back((d == 8'h00) ? 8'h20 : d);
      gap = DATA_GAP;
    end
    exp_sub = !is_cmd && (d == 8'h00);
    foreach (bytes_q[b]) begin
      cur = bytes_q[b];
      for (int bit_n = 0; bit_n < 10; bit_n++)
        for (int c = 0; c < int'(CPB); c++)
          exp_q.push_back((bit_n == 0) ? 1'b0 : (bit_n == 9) ? 1'b1 : cur[bit_n-1]);
    end
    for (int g = 0; g < int'(gap); g++) exp_q.push_back(1'b1);

    ifc.in_valid  = 1'b1;
    ifc.in_is_cmd = is_cmd;
    ifc.in_data   = d;
    @(negedge clk);
    ifc.in_valid  = hold;
    ifc.in_is_cmd = nxt_cmd;
    ifc.in_data   = nxt_d;

    for (int i = 0; i < exp_q.size(); i++) begin
      check_val("txd", i, int'(txd), int'(exp_q[i]));
      check_val("busy", i, int'(busy), 1);
      check_val("in_ready_busy", i, int'(ifc.in_ready), 0);
      check_val("sub_flag", i, int'(sub_flag), int'(exp_sub && i == 0));
      cap.push_back(txd);
      @(negedge clk);
    end
    check_val("idle_busy", exp_q.size(), int'(busy), 0);
    check_val("idle_ready", exp_q.size(), int'(ifc.in_ready), 1);
    check_val("idle_txd", exp_q.size(), int'(txd), 1);

    k = 0;
    while (k < cap.size()) begin
      if (cap[k] == 1'b0 && k + 10 * CPB <= cap.size()) begin
        acc = '0;
        for (int b = 0; b < 8; b++) acc[b] = cap[k + CPB / 2 + CPB * (b + 1)];
        check_val("stop_bit", int'(dec_q.size()), int'(cap[k + CPB / 2 + CPB * 9]), 1);
        dec_q.push_back(acc);
        k += 10 * CPB;
      end else begin
        k++;
      end
    end
    check_val("dec_count", int'(d), dec_q.size(), bytes_q.size());
    foreach (bytes_q[b])
      if (b < dec_q.size()) check_val("dec_byte", b, int'(dec_q[b]), int'(bytes_q[b]));
  endtask

  initial begin
    logic       r_cmd;
    logic [7:0] r_d;

    errors = 0;
    checks = 0;
    resetn = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.in_is_cmd = 1'b0;
    ifc.in_data   = 8'h00;

    repeat (2) @(negedge clk);
    check_val("rst_txd", 0, int'(txd), 1);
    check_val("rst_ready", 0, int'(ifc.in_ready), 0);
    check_val("rst_busy", 0, int'(busy), 0);
    check_val("rst_sub", 0, int'(sub_flag), 0);
    resetn = 1'b1;
    @(negedge clk);

    run_req(1'b0, 8'h41, 1'b0, 1'b1, 8'h5A);
    run_req(1'b1, 8'h01, 1'b0, 1'b0, 8'hA5);
    run_req(1'b0, 8'h00, 1'b0, 1'b1, 8'h00);
    run_req(1'b0, 8'h48, 1'b1, 1'b0, 8'h69);
    run_req(1'b0, 8'h69, 1'b0, 1'b0, 8'h77);
    run_req(1'b0, 8'hFF, 1'b0, 1'b0, 8'h00);

    // Abort a frame on its 15th clock, where 0x41 has a low data bit on TxD
    ifc.in_valid  = 1'b1;
    ifc.in_is_cmd = 1'b0;
    ifc.in_data   = 8'h41;
    @(negedge clk);
    ifc.in_valid = 1'b0;
    repeat (14) @(negedge clk);
    check_val("pre_reset_txd", 15, int'(txd), 0);
    #2 resetn = 1'b0;
    #1;
    check_val("reset_txd", 0, int'(txd), 1);
    check_val("reset_busy", 0, int'(busy), 0);
    check_val("reset_ready", 0, int'(ifc.in_ready), 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    #1;
    check_val("post_reset_ready", 0, int'(ifc.in_ready), 1);
    check_val("post_reset_txd", 0, int'(txd), 1);
    run_req(1'b0, 8'h3C, 1'b0, 1'b0, 8'h00);

    for (int n = 0; n < 6; n++) begin
      r_cmd = 1'($urandom_range(0, 1));
      r_d   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      run_req(r_cmd, r_d, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
